core_debug_controller: RTL and testbench

Parametrised run-control and trace controller between a host command link and a RISC-V core under test. Gates core execution with a clock enable, holds core reset, and runs/halts/single-steps by cycles or by retired instructions. It halts on configurable PC breakpoints or traps, all observed through the core's RVFI retirement port. Retired PCs and instructions are captured in a trace FIFO that the host drains through the same command link.

---
 rtl/core_debug_controller_if.sv | 24 ++
 rtl/core_debug_controller.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_core_debug_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_debug_controller_if.sv
// Host command/response link of the core debug controller.
// master = host side, slave = controller side.
interface core_debug_controller_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_sel;
  logic [31:0] cmd_arg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_arg,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_arg,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/core_debug_controller.sv
// Run-control, breakpoint and RVFI trace controller for a core under test.
// Define CONTROLLER_TRACE_EN to build the retirement trace FIFO.
module core_debug_controller #(
  parameter int CLK_FREQ        = 25000000,
  parameter int NUM_BREAKPOINTS = 2,
  parameter int TRACE_DEPTH     = 16,
  parameter int CYCLE_WIDTH     = 32
) (
  input  logic        clk,
  input  logic        reset,
  core_debug_controller_if.slave host,
  output logic        clk_core_en,
  output logic        reset_core,
  input  logic        rvfi_valid,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap
);

  localparam logic [1:0] ST_HALT      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_STEP_CYC  = 2'd2;
  localparam logic [1:0] ST_STEP_INSN = 2'd3;

  localparam logic [3:0] OP_RESET     = 4'd1;
  localparam logic [3:0] OP_RUN       = 4'd2;
  localparam logic [3:0] OP_HALT      = 4'd3;
  localparam logic [3:0] OP_STEP_CYC  = 4'd4;
  localparam logic [3:0] OP_STEP_INSN = 4'd5;
  localparam logic [3:0] OP_SET_BP    = 4'd6;
  localparam logic [3:0] OP_CLR_BP    = 4'd7;
  localparam logic [3:0] OP_STATUS    = 4'd8;
  localparam logic [3:0] OP_TRACE_POP = 4'd9;
  localparam logic [3:0] OP_READ_INSN = 4'd10;
  localparam logic [3:0] OP_CYC_LO    = 4'd11;
  localparam logic [3:0] OP_CYC_HI    = 4'd12;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] step_cnt;
  logic [31:0] step_nxt;

  logic [31:0] bp_addr [NUM_BREAKPOINTS];
  logic [NUM_BREAKPOINTS-1:0] bp_en;
  logic [2:0]  bp_idx;
  logic [2:0]  bp_first;
  logic        bp_match;
  logic        bp_hit;
  logic        trap_seen;

  logic [CYCLE_WIDTH-1:0] cycles;
  logic [63:0] cyc64;

  logic [7:0]  trace_count;
  logic        trace_ovf;
  logic [31:0] trace_head;
  logic [31:0] last_insn;

  logic [31:0] status;
  logic [31:0] rsp_nxt;

  logic fire;
  logic retire;
  logic halted;
  logic status_rd;
  logic bp_event;
  logic trap_event;
  logic unused_ok;

  assign host.cmd_ready = !host.rsp_valid;

  assign fire      = host.cmd_valid
                   && host.cmd_ready;
  assign retire    = rvfi_valid && clk_core_en;
  assign halted    = state == ST_HALT;
  assign status_rd = fire
                   && host.cmd_op == OP_STATUS;

  // Lowest matching comparator wins.
  always_comb begin
    bp_match = 1'b0;
    bp_first = '0;
    for (int i = NUM_BREAKPOINTS - 1; i >= 0; i--) begin
      if (bp_en[i] && bp_addr[i] == rvfi_pc_rdata) begin
        bp_match = 1'b1;
        bp_first = 3'(i);
      end
    end
  end

  assign bp_event   = retire && bp_match;
  assign trap_event = retire && rvfi_trap;

  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    if (fire && host.cmd_op == OP_HALT) begin
      state_nxt = ST_HALT;
    end else if (bp_event || trap_event) begin
      state_nxt = ST_HALT;
    end else begin
      case (state)
        ST_HALT: begin
          if (fire) begin
            if (host.cmd_op == OP_RUN) begin
              state_nxt = ST_RUN;
            end else if (host.cmd_arg != 32'd0) begin
              if (host.cmd_op == OP_STEP_CYC) begin
                state_nxt = ST_STEP_CYC;
                step_nxt  = host.cmd_arg;
              end else if (host.cmd_op == OP_STEP_INSN) begin
                state_nxt = ST_STEP_INSN;
                step_nxt  = host.cmd_arg;
              end
            end
          end
        end
        ST_STEP_CYC: begin
          step_nxt = step_cnt - 32'd1;
          if (step_cnt == 32'd1)
            state_nxt = ST_HALT;
        end
        ST_STEP_INSN: begin
          if (retire) begin
            step_nxt = step_cnt - 32'd1;
            if (step_cnt == 32'd1)
              state_nxt = ST_HALT;
          end
        end
        default: ;
      endcase
    end
  end

  assign cyc64 = 64'(cycles);

  assign status = {8'h00, trace_count,
                   5'h00, bp_idx,
                   2'b00, trace_ovf,
                   trap_seen, bp_hit,
                   reset_core, state};

  always_comb begin
    case (host.cmd_op)
      OP_STATUS:    rsp_nxt = status;
      OP_TRACE_POP: rsp_nxt = trace_head;
      OP_READ_INSN: rsp_nxt = last_insn;
      OP_CYC_LO:    rsp_nxt = cyc64[31:0];
      OP_CYC_HI:    rsp_nxt = cyc64[63:32];
      default:      rsp_nxt = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_HALT;
      step_cnt       <= '0;
      clk_core_en    <= 1'b0;
      reset_core     <= 1'b1;
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
      bp_hit         <= 1'b0;
      bp_idx         <= '0;
      trap_seen      <= 1'b0;
      cycles         <= '0;
    end else begin
      state       <= state_nxt;
      step_cnt    <= step_nxt;
      clk_core_en <= state_nxt != ST_HALT;
      if (fire) begin
        host.rsp_valid <= 1'b1;
        host.rsp_data  <= rsp_nxt;
      end else if (host.rsp_ready) begin
        host.rsp_valid <= 1'b0;
      end
      if (fire && host.cmd_op == OP_RESET)
        reset_core <= host.cmd_arg[0];
      if (bp_event) begin
        bp_hit <= 1'b1;
        bp_idx <= bp_first;
      end else if (status_rd) begin
        bp_hit <= 1'b0;
      end
      if (trap_event)
        trap_seen <= 1'b1;
      else if (status_rd)
        trap_seen <= 1'b0;
      if (clk_core_en)
        cycles <= cycles + CYCLE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BREAKPOINTS; i++)
        bp_addr[i] <= '0;
      bp_en <= '0;
    end else if (fire) begin
      for (int i = 0; i < NUM_BREAKPOINTS; i++) begin
        if (host.cmd_sel == 3'(i)) begin
          if (host.cmd_op == OP_SET_BP && halted) begin
            bp_addr[i] <= host.cmd_arg;
            bp_en[i]   <= 1'b1;
          end
          if (host.cmd_op == OP_CLR_BP)
            bp_en[i] <= 1'b0;
        end
      end
    end
  end

`ifdef CONTROLLER_TRACE_EN
  localparam int AW = $clog2(TRACE_DEPTH);

  logic [31:0] pc_mem   [TRACE_DEPTH];
  logic [31:0] insn_mem [TRACE_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   last_insn_q;
  logic          ovf_q;
  logic          full;
  logic          pop;

  assign full = count == (AW+1)'(TRACE_DEPTH);
  assign pop  = fire
              && host.cmd_op == OP_TRACE_POP
              && count != '0;

  always_ff @(posedge clk) begin
    if (retire) begin
      pc_mem[wr_ptr]   <= rvfi_pc_rdata;
      insn_mem[wr_ptr] <= rvfi_insn;
    end
  end

  // A push into a full FIFO drops the oldest entry by advancing rd_ptr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      ovf_q       <= 1'b0;
      last_insn_q <= '0;
    end else begin
      if (retire)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop || (retire && full))
        rd_ptr <= rd_ptr + AW'(1);
      if (retire && !pop && !full)
        count <= count + (AW+1)'(1);
      else if (pop && !retire)
        count <= count - (AW+1)'(1);
      if (retire && full && !pop)
        ovf_q <= 1'b1;
      else if (status_rd)
        ovf_q <= 1'b0;
      if (pop)
        last_insn_q <= insn_mem[rd_ptr];
    end
  end

  assign trace_count = 8'(count);
  assign trace_ovf   = ovf_q;
  assign last_insn   = last_insn_q;
  assign trace_head  = (count != '0)
                     ? pc_mem[rd_ptr]
                     : 32'hFFFF_FFFF;
`else
  assign trace_count = 8'h00;
  assign trace_ovf   = 1'b0;
  assign last_insn   = 32'd0;
  assign trace_head  = 32'hFFFF_FFFF;
`endif

  assign unused_ok = ^{rvfi_insn,
                       32'(CLK_FREQ),
                       32'(TRACE_DEPTH)};

endmodule

// File: tb/tb_core_debug_controller.sv
// Randomized bench for core_debug_controller against a transaction-level
// model (queue-based trace, countdown run budget).
module tb_core_debug_controller;

  localparam int NB    = 2;
  localparam int DEPTH = 16;
  localparam int CW    = 32;
`ifdef CONTROLLER_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_core_en;
  logic        reset_core;

  logic        d_cmd_valid;
  logic [3:0]  d_op;
  logic [2:0]  d_sel;
  logic [31:0] d_arg;
  logic        d_rsp_ready;
  logic        d_rvfi_valid;
  logic [31:0] d_pc;
  logic [31:0] d_insn;
  logic        d_trap;

  core_debug_controller_if hif();

  assign hif.cmd_valid = d_cmd_valid;
  assign hif.cmd_op    = d_op;
  assign hif.cmd_sel   = d_sel;
  assign hif.cmd_arg   = d_arg;
  assign hif.rsp_ready = d_rsp_ready;

  core_debug_controller #(
    .CLK_FREQ(25000000),
    .NUM_BREAKPOINTS(NB),
    .TRACE_DEPTH(DEPTH),
    .CYCLE_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .host(hif),
    .clk_core_en(clk_core_en),
    .reset_core(reset_core),
    .rvfi_valid(d_rvfi_valid),
    .rvfi_pc_rdata(d_pc),
    .rvfi_insn(d_insn),
    .rvfi_trap(d_trap)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int en_cycles = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h",
                  tag, got, exp);
  endtask

  // Reference model state
  int          m_mode;
  longint      m_left;
  bit          m_rst_core;
  logic [31:0] m_bp_addr [8];
  bit          m_bp_on [8];
  bit          m_bp_hit;
  int          m_bp_idx;
  bit          m_trap;
  bit          m_ovf;
  logic [63:0] m_q [$];
  logic [31:0] m_last_insn;
  logic [63:0] m_cycles;
  bit          m_rsp_valid;
  logic [31:0] m_rsp_data;

  task automatic m_reset();
    m_mode = 0; m_left = 0;
    m_rst_core = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m_bp_addr[i] = '0; m_bp_on[i] = 1'b0;
    end
    m_bp_hit = 0; m_bp_idx = 0; m_trap = 0;
    m_ovf = 0; m_q.delete();
    m_last_insn = '0; m_cycles = '0;
    m_rsp_valid = 0; m_rsp_data = '0;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(m_mode);
    s |= 32'(m_rst_core) << 2;
    s |= 32'(m_bp_hit) << 3;
    s |= 32'(m_trap) << 4;
    s |= 32'(m_ovf) << 5;
    s |= 32'(m_bp_idx) << 8;
    s |= 32'(m_q.size()) << 16;
    return s;
  endfunction

  task automatic m_step(output bit fired);
    bit en, fire, ret, trap, srd, pop_ok;
    int hit;
    logic [31:0] rsp;
    en   = m_mode != 0;
    fire = d_cmd_valid && !m_rsp_valid;
    ret  = d_rvfi_valid && en;
    trap = ret && d_trap;
    srd  = fire && d_op == 4'd8;
    hit  = -1;
    if (ret)
      for (int i = 0; i < NB; i++)
        if (hit < 0 && m_bp_on[i] && m_bp_addr[i] == d_pc)
          hit = i;
    rsp = 32'd0;
    case (d_op)
      4'd8:  rsp = m_status();
      4'd9:  rsp = (m_q.size() > 0) ? m_q[0][63:32] : 32'hFFFF_FFFF;
      4'd10: rsp = m_last_insn;
      4'd11: rsp = m_cycles[31:0];
      4'd12: rsp = m_cycles[63:32];
      default: rsp = 32'd0;
    endcase
    if (fire) begin
      m_rsp_valid = 1; m_rsp_data = rsp;
    end else if (m_rsp_valid && d_rsp_ready) begin
      m_rsp_valid = 0;
    end
    if (TRACE_EN) begin
      pop_ok = fire && d_op == 4'd9 && m_q.size() > 0;
      if (pop_ok) begin
        m_last_insn = m_q[0][31:0];
        void'(m_q.pop_front());
      end
      if (ret) begin
        m_q.push_back({d_pc, d_insn});
        if (m_q.size() > DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1;
        end else if (srd) m_ovf = 0;
      end else if (srd) m_ovf = 0;
    end
    if (hit >= 0) begin
      m_bp_hit = 1; m_bp_idx = hit;
    end else if (srd) m_bp_hit = 0;
    if (trap) m_trap = 1;
    else if (srd) m_trap = 0;
    if (en) begin
      m_cycles = m_cycles + 64'd1;
      if (CW < 64) m_cycles &= (64'd1 << CW) - 64'd1;
    end
    if (fire && d_op == 4'd1) m_rst_core = d_arg[0];
    if (fire && int'(d_sel) < NB) begin
      if (d_op == 4'd6 && m_mode == 0) begin
        m_bp_addr[d_sel] = d_arg; m_bp_on[d_sel] = 1;
      end
      if (d_op == 4'd7) m_bp_on[d_sel] = 0;
    end
    if (fire && d_op == 4'd3) m_mode = 0;
    else if (hit >= 0 || trap) m_mode = 0;
    else if (m_mode == 0) begin
      if (fire && d_op == 4'd2) m_mode = 1;
      else if (fire && (d_op == 4'd4 || d_op == 4'd5) && d_arg != 0) begin
        m_left = longint'(d_arg);
        m_mode = (d_op == 4'd4) ? 2 : 3;
      end
    end else if (m_mode == 2 || (m_mode == 3 && ret)) begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
    fired = fire;
  endtask

  task automatic tick(output bit fired);
    m_step(fired);
    @(posedge clk); #1;
    if (clk_core_en) en_cycles++;
    chk("clk_core_en", 32'(clk_core_en), 32'(m_mode != 0));
    chk("reset_core", 32'(reset_core), 32'(m_rst_core));
    chk("cmd_ready", 32'(hif.cmd_ready), 32'(!m_rsp_valid));
    chk("rsp_valid", 32'(hif.rsp_valid), 32'(m_rsp_valid));
    chk("rsp_data", hif.rsp_data, m_rsp_data);
  endtask

  task automatic idle(input int n);
    bit f;
    for (int i = 0; i < n; i++) tick(f);
  endtask

  task automatic cmd(input logic [3:0] op, input logic [2:0] sel,
                     input logic [31:0] arg, output logic [31:0] rsp);
    bit f, got;
    got = 0;
    d_cmd_valid = 1; d_op = op; d_sel = sel; d_arg = arg;
    d_rsp_ready = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(f); got = f;
    end
    d_cmd_valid = 0;
    chk("cmd_accept", 32'(got), 32'd1);
    rsp = hif.rsp_data;
    tick(f);
  endtask

  task automatic drain();
    logic [31:0] r;
    for (int i = 0; i < DEPTH + 4; i++) begin
      cmd(4'd9, 3'd0, 32'd0, r);
      if (r == 32'hFFFF_FFFF) break;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_en"}, 32'(clk_core_en), 32'd0);
    chk({tag, "_rst_core"}, 32'(reset_core), 32'd1);
    chk({tag, "_cmd_ready"}, 32'(hif.cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(hif.rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, hif.rsp_data, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    bit f;
    reset = 1;
    d_cmd_valid = 0; d_op = '0; d_sel = '0; d_arg = '0;
    d_rsp_ready = 1; d_rvfi_valid = 0; d_pc = '0;
    d_insn = '0; d_trap = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    reset = 0;

    cmd(4'd1, 3'd0, 32'd0, r);
    chk("reset_core_cleared", 32'(reset_core), 32'd0);
    cmd(4'd8, 3'd0, 32'd0, r);
    chk("status_idle", r, 32'd0);

    en_cycles = 0;
    cmd(4'd4, 3'd0, 32'd5, r);
    idle(6);
    chk("step_cyc_len", 32'(en_cycles), 32'd5);
    cmd(4'd11, 3'd0, 32'd0, r);
    chk("cycles_lo", r, 32'd5);
    cmd(4'd8, 3'd0, 32'd0, r);
    chk("step_cyc_state", r & 32'h3, 32'd0);

    cmd(4'd6, 3'd1, 32'h10, r);
    cmd(4'd2, 3'd0, 32'd0, r);
    for (int pc = 0; pc <= 'h10; pc += 4) begin
      idle($urandom_range(0, 2));
      d_rvfi_valid = 1; d_pc = 32'(pc); d_insn = $urandom;
      tick(f);
      d_rvfi_valid = 0;
      if (pc < 'h10) chk("bp_running", 32'(clk_core_en), 32'd1);
    end
    chk("bp_halt", 32'(clk_core_en), 32'd0);
    cmd(4'd8, 3'd0, 32'd0, r);
    chk("bp_status", r & 32'h718, 32'h108);
    cmd(4'd8, 3'd0, 32'd0, r);
    chk("bp_status_clr", r & 32'h8, 32'd0);
    drain();

    cmd(4'd7, 3'd1, 32'd0, r);
    cmd(4'd5, 3'd0, 32'd3, r);
    for (int k = 0; k < 3; k++) begin
      d_rvfi_valid = 1; d_pc = 32'h100 + 32'(4 * k);
      d_insn = $urandom;
      tick(f);
      d_rvfi_valid = 0;
      if (k < 2) begin
        chk("step_insn_run", 32'(clk_core_en), 32'd1);
        tick(f);
      end
    end
    chk("step_insn_halt", 32'(clk_core_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cmd(4'd9, 3'd0, 32'd0, r);
      chk("pop_order", r,
          TRACE_EN ? 32'h100 + 32'(4 * k) : 32'hFFFF_FFFF);
    end
    cmd(4'd9, 3'd0, 32'd0, r);
    chk("pop_empty", r, 32'hFFFF_FFFF);

    cmd(4'd2, 3'd0, 32'd0, r);
    for (int k = 0; k < DEPTH + 2; k++) begin
      d_rvfi_valid = 1; d_pc = 32'h200 + 32'(4 * k);
      d_insn = $urandom;
      tick(f);
    end
    d_rvfi_valid = 0;
    cmd(4'd3, 3'd0, 32'd0, r);
    cmd(4'd8, 3'd0, 32'd0, r);
    chk("ovf_status", r & 32'h00FF_0020,
        TRACE_EN ? (32'(DEPTH) << 16) | 32'h20 : 32'd0);
    cmd(4'd9, 3'd0, 32'd0, r);
    chk("ovf_first_pop", r, TRACE_EN ? 32'h208 : 32'hFFFF_FFFF);
    drain();

    cmd(4'd2, 3'd0, 32'd0, r);
    d_rvfi_valid = 1; d_pc = 32'h300; d_trap = 1;
    tick(f);
    d_rvfi_valid = 0; d_trap = 0;
    chk("trap_halt", 32'(clk_core_en), 32'd0);
    cmd(4'd8, 3'd0, 32'd0, r);
    chk("trap_status", r & 32'h13, 32'h10);

    cmd(4'd6, 3'd0, 32'h400, r);
    cmd(4'd2, 3'd0, 32'd0, r);
    d_cmd_valid = 1; d_op = 4'd3;
    d_rvfi_valid = 1; d_pc = 32'h400;
    tick(f);
    d_cmd_valid = 0; d_rvfi_valid = 0;
    chk("halt_bp_en", 32'(clk_core_en), 32'd0);
    tick(f);
    cmd(4'd8, 3'd0, 32'd0, r);
    chk("halt_bp_status", r & 32'h70B, 32'h8);
    drain();

    for (int i = 0; i < 3000; i++) begin
      d_cmd_valid = $urandom_range(0, 2) == 0;
      d_op  = 4'($urandom_range(0, 15));
      d_sel = 3'($urandom_range(0, 3));
      case (d_op)
        4'd4, 4'd5: d_arg = 32'($urandom_range(0, 12));
        4'd6: d_arg = 32'($urandom_range(0, 15)) << 2;
        default: d_arg = $urandom;
      endcase
      d_rsp_ready  = $urandom_range(0, 3) != 0;
      d_rvfi_valid = $urandom_range(0, 1) == 1;
      d_pc   = 32'($urandom_range(0, 15)) << 2;
      d_insn = $urandom;
      d_trap = $urandom_range(0, 39) == 0;
      if (i == 1500) begin
        #2 reset = 1;
        #1 reset_checks("async_reset");
        m_reset();
        @(posedge clk); #1;
        reset = 0;
      end
      tick(f);
    end

    d_cmd_valid = 0; d_rvfi_valid = 0; d_rsp_ready = 1;
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
